// File: rtl/vec_in_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_in_pkg                                                                 |
// | Shared types and default sizing for the vec_in_loader input staging block. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vec_in_pkg;

  localparam int VEC_INVECWIDTH = 8;
  localparam int VEC_WIDTH      = 8;
  localparam int VEC_CHUNK      = 2;

  function automatic int calc_nbeats(input int invecwidth, input int chunk);
    return invecwidth / chunk;
  endfunction

  localparam int NBEATS = calc_nbeats(VEC_INVECWIDTH, VEC_CHUNK);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  typedef logic signed [VEC_WIDTH-1:0] elem_t;

endpackage
`default_nettype wire

// File: rtl/vec_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_bank                                                                   |
// | One vector register bank: element write port, synchronous clear and a     |
// | chunk read mux. Instantiated once, or twice with VEC_IN_DOUBLE_BUFFER_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vec_bank
  import vec_in_pkg::*;
#(
  parameter int INVECWIDTH = VEC_INVECWIDTH,
  parameter int WIDTH      = VEC_WIDTH,
  parameter int CHUNK      = VEC_CHUNK,
  parameter int AW         = 3,
  parameter int BW         = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_clr,
  input  logic [BW-1:0]          i_ridx,
  output logic [CHUNK*WIDTH-1:0] o_chunk
);

  logic [WIDTH-1:0] r_mem   [INVECWIDTH];
  logic [WIDTH-1:0] w_mem_n [INVECWIDTH];

  always_comb begin
    w_mem_n = r_mem;
    if (i_clr) begin
      for (int i = 0; i < INVECWIDTH; i++) w_mem_n[i] = '0;
    end else if (i_we) begin
      w_mem_n[i_waddr] = i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INVECWIDTH; i++) r_mem[i] <= '0;
    end else begin
      r_mem <= w_mem_n;
    end
  end

  // Read from the next-state image so a beat launched on the commit cycle
  // already carries an element written in that same cycle.
  always_comb begin
    o_chunk = '0;
    for (int k = 0; k < CHUNK; k++) begin
      if (int'(i_ridx) * CHUNK + k < INVECWIDTH)
        o_chunk[k*WIDTH +: WIDTH] = w_mem_n[AW'(int'(i_ridx) * CHUNK + k)];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vec_in_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_in_loader                                                              |
// | Assembles input vectors one element per cycle and streams them as chunks  |
// | over valid/ready. VEC_IN_DOUBLE_BUFFER_EN selects two banks (else one).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vec_in_loader
  import vec_in_pkg::*;
#(
  parameter int INVECWIDTH = VEC_INVECWIDTH,
  parameter int WIDTH      = VEC_WIDTH,
  parameter int CHUNK      = VEC_CHUNK
) (
  input  logic                   clk_100mhz,
  input  logic                   sys_rst,
  input  logic                   wr_in,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_data_ready,
  output logic [CHUNK*WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   in_full,
  output logic                   wr_overflow
);

  localparam int NB = calc_nbeats(INVECWIDTH, CHUNK);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = (INVECWIDTH > 1) ? $clog2(INVECWIDTH) : 1;
  localparam int PW = $clog2(INVECWIDTH + 1);
`ifdef VEC_IN_DOUBLE_BUFFER_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif

  logic [PW-1:0]          r_wp;
  logic                   r_wr_bank;
  logic                   r_wr_act;
  logic                   r_rd_ptr;
  bank_state_e            r_bstate   [2];
  bank_state_e            w_bstate_n [2];
  logic                   w_wr_bank_n;
  logic                   w_wr_act_n;
  rd_state_e              r_rd_state;
  rd_state_e              w_rd_state_n;
  logic [BW-1:0]          r_beat;
  logic [CHUNK*WIDTH-1:0] r_out_data;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic                   r_ovf;

  logic                   w_other;
  logic                   w_wr_ok;
  logic [PW-1:0]          w_wp_eff;
  logic                   w_commit;
  logic                   w_drop;
  logic                   w_hs;
  logic                   w_last_beat;
  logic                   w_free;
  logic                   w_start;
  logic [BW-1:0]          w_ridx;
  logic [CHUNK*WIDTH-1:0] w_chunk [2];

  assign w_other     = (NBANKS == 2) ? ~r_wr_bank : r_wr_bank;
  assign w_wr_ok     = wr_in && r_wr_act && (r_wp < PW'(INVECWIDTH));
  assign w_wp_eff    = r_wp + PW'(w_wr_ok);
  assign w_commit    = in_data_ready && r_wr_act && (w_wp_eff != '0);
  assign w_drop      = (wr_in && !w_wr_ok) || (in_data_ready && !r_wr_act);
  assign w_hs        = r_out_valid && out_ready;
  assign w_last_beat = (r_beat == BW'(NB - 1));
  assign w_free      = (r_rd_state == STREAM) && w_hs && w_last_beat;
  assign w_ridx      = w_start ? '0 : r_beat + 1'b1;

  // Bank ownership: a commit hands the writer the other bank if it is free,
  // otherwise the writer waits and the next freed bank goes straight to it.
  always_comb begin
    w_bstate_n  = r_bstate;
    w_wr_bank_n = r_wr_bank;
    w_wr_act_n  = r_wr_act;
    if (w_commit) begin
      w_bstate_n[r_wr_bank] = FULL;
      if (r_bstate[w_other] == EMPTY) begin
        w_wr_bank_n         = w_other;
        w_bstate_n[w_other] = FILLING;
      end else begin
        w_wr_act_n = 1'b0;
      end
    end
    if (w_free) begin
      w_bstate_n[r_rd_ptr] = EMPTY;
      if (!w_wr_act_n) begin
        w_wr_act_n           = 1'b1;
        w_wr_bank_n          = r_rd_ptr;
        w_bstate_n[r_rd_ptr] = FILLING;
      end
    end
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      r_wp        <= '0;
      r_wr_bank   <= 1'b0;
      r_wr_act    <= 1'b1;
      r_bstate[0] <= FILLING;
      r_bstate[1] <= EMPTY;
      r_ovf       <= 1'b0;
    end else begin
      r_wp      <= w_commit ? '0 : w_wp_eff;
      r_wr_bank <= w_wr_bank_n;
      r_wr_act  <= w_wr_act_n;
      r_bstate  <= w_bstate_n;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) r_rd_state <= IDLE;
    else         r_rd_state <= w_rd_state_n;
  end

  always_comb begin
    w_rd_state_n = r_rd_state;
    w_start      = 1'b0;
    case (r_rd_state)
      IDLE: begin
        if (r_bstate[r_rd_ptr] == FULL || (w_commit && r_wr_bank == r_rd_ptr)) begin
          w_start      = 1'b1;
          w_rd_state_n = STREAM;
        end
      end
      STREAM: begin
        if (w_free) w_rd_state_n = IDLE;
      end
      default: w_rd_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      r_beat      <= '0;
      r_rd_ptr    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_start) begin
      r_beat      <= '0;
      r_out_valid <= 1'b1;
      r_out_data  <= w_chunk[r_rd_ptr];
      r_out_last  <= (NB == 1);
    end else if (w_free) begin
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_rd_ptr    <= (NBANKS == 2) ? ~r_rd_ptr : 1'b0;
    end else if (w_hs) begin
      r_beat      <= w_ridx;
      r_out_data  <= w_chunk[r_rd_ptr];
      r_out_last  <= (w_ridx == BW'(NB - 1));
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    if (gi < NBANKS) begin : g_inst
      vec_bank #(
        .INVECWIDTH (INVECWIDTH),
        .WIDTH      (WIDTH),
        .CHUNK      (CHUNK),
        .AW         (AW),
        .BW         (BW)
      ) u_bank (
        .clk     (clk_100mhz),
        .rst     (sys_rst),
        .i_we    (w_wr_ok && (r_wr_bank == 1'(gi))),
        .i_waddr (r_wp[AW-1:0]),
        .i_wdata (in_data),
        .i_clr   (w_free && (r_rd_ptr == 1'(gi))),
        .i_ridx  (w_ridx),
        .o_chunk (w_chunk[gi])
      );
    end else begin : g_none
      assign w_chunk[gi] = '0;
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign in_full     = ~r_wr_act;
  assign wr_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vec_in_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vec_in_loader                                                           |
// | Directed vector table, corner sequences and random traffic vs a queue     |
// | model. Honours VEC_IN_DOUBLE_BUFFER_EN for the bank count.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vec_in_loader;

  localparam int IW = 8;
  localparam int W  = 8;
  localparam int C  = 2;
  localparam int NB = IW / C;
  localparam int CW = C * W;
  localparam int VW = IW * W;
`ifdef VEC_IN_DOUBLE_BUFFER_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          wr_in = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_data_ready = 1'b0;
  logic [CW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          in_full;
  logic          wr_overflow;

  always #5 clk = ~clk;

  vec_in_loader #(.INVECWIDTH(IW), .WIDTH(W), .CHUNK(C)) dut (
    .clk_100mhz    (clk),
    .sys_rst       (sys_rst),
    .wr_in         (wr_in),
    .in_data       (in_data),
    .in_data_ready (in_data_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .in_full       (in_full),
    .wr_overflow   (wr_overflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference: a fill buffer plus a FIFO of committed vectors; the head of
  // the FIFO is the vector being streamed.
  logic [VW-1:0] m_fill;
  int            m_cnt;
  bit            m_wown, m_stream, m_valid, m_ovf;
  int            m_beat;
  logic [VW-1:0] vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill = '0; m_cnt = 0; m_wown = 1'b1; m_stream = 1'b0;
    m_valid = 1'b0; m_ovf = 1'b0; m_beat = 0;
    vq.delete();
  endtask

  task automatic model_tick();
    bit was_stream;
    bit hs;
    was_stream = m_stream;
    hs = m_valid && out_ready;
    if (wr_in) begin
      if (m_wown && m_cnt < IW) begin
        m_fill[m_cnt*W +: W] = in_data;
        m_cnt++;
      end else m_ovf = 1'b1;
    end
    if (in_data_ready) begin
      if (!m_wown) m_ovf = 1'b1;
      else if (m_cnt > 0) begin
        vq.push_back(m_fill);
        m_fill = '0;
        m_cnt  = 0;
        if (vq.size() >= NBANKS) m_wown = 1'b0;
      end
    end
    if (was_stream) begin
      if (hs) begin
        if (m_beat == NB - 1) begin
          void'(vq.pop_front());
          m_stream = 1'b0; m_valid = 1'b0; m_beat = 0;
          if (!m_wown) m_wown = 1'b1;
        end else m_beat++;
      end
    end else if (vq.size() > 0) begin
      m_stream = 1'b1; m_valid = 1'b1; m_beat = 0;
    end
  endtask

  task automatic model_check();
    logic [VW-1:0] t;
    logic [CW-1:0] ed;
    chk("m_valid", out_valid, m_valid);
    chk("m_last", out_last, m_valid && (m_beat == NB - 1));
    chk("m_in_full", in_full, !m_wown);
    chk("m_ovf", wr_overflow, m_ovf);
    if (m_valid) begin
      t  = vq[0];
      ed = t[m_beat*CW +: CW];
      chk("m_data", out_data, ed);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (sys_rst) model_reset();
    else model_tick();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    wr_in = 0; in_data_ready = 0; out_ready = 0; in_data = '0;
    sys_rst = 1;
    step();
    step();
    sys_rst = 0;
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_in_full", in_full, 0);
    chk("rst_ovf", wr_overflow, 0);
  endtask

  typedef struct {
    int          n;
    int          v0;
    int          stp;
    bit          tog;
    logic [63:0] exp;
    bit          ovf;
  } dir_t;

  dir_t tbl[4];

  task automatic run_dir(input dir_t d);
    logic [63:0] e;
    int beat;
    int cyc;
    e = d.exp;
    for (int i = 0; i < d.n; i++) begin
      wr_in = 1; in_data = W'(d.v0 + i * d.stp);
      step();
    end
    wr_in = 0;
    chk("dir_ovf_writes", wr_overflow, d.ovf);
    in_data_ready = 1;
    step();
    in_data_ready = 0;
    chk("dir_first_valid", out_valid, 1);
    beat = 0; cyc = 0;
    while (beat < NB && cyc < 40) begin
      out_ready = d.tog ? (cyc % 2 == 0) : 1'b1;
      if (out_valid && out_ready) begin
        chk("dir_beat_data", out_data, e[beat*CW +: CW]);
        chk("dir_beat_last", out_last, beat == NB - 1);
        beat++;
      end
      step();
      cyc++;
    end
    chk("dir_beats_seen", beat, NB);
    chk("dir_valid_after", out_valid, 0);
    chk("dir_ovf_sticky", wr_overflow, d.ovf);
    out_ready = 0;
  endtask

  initial begin
    tbl[0] = '{8,  1,  1, 1'b0, 64'h0807_0605_0403_0201, 1'b0};
    tbl[1] = '{8, -1, -1, 1'b1, 64'hF8F9_FAFB_FCFD_FEFF, 1'b0};
    tbl[2] = '{3,  5,  1, 1'b0, 64'h0000_0000_0007_0605, 1'b0};
    tbl[3] = '{9,  1,  1, 1'b0, 64'h0807_0605_0403_0201, 1'b1};
    model_reset();

    for (int t = 0; t < 4; t++) begin
      do_reset();
      run_dir(tbl[t]);
    end

    // Two vectors committed against a stalled reader, then drained.
    do_reset();
    for (int i = 0; i < IW; i++) begin wr_in = 1; in_data = 8'd1; step(); end
    wr_in = 0; in_data_ready = 1; step(); in_data_ready = 0;
    for (int i = 0; i < IW; i++) begin wr_in = 1; in_data = 8'd2; step(); end
    wr_in = 0; in_data_ready = 1; step(); in_data_ready = 0;
    wr_in = 1; in_data = 8'd3; step(); wr_in = 0;
    chk("dbl_in_full", in_full, 1);
    chk("dbl_ovf", wr_overflow, 1);
    out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      bit expv;
      expv = (c < 4) || (NBANKS == 2 && c >= 5 && c < 9);
      chk("dbl_seq_valid", out_valid, expv);
      if (expv) chk("dbl_seq_data", out_data, (c < 4) ? 16'h0101 : 16'h0202);
      if (c == 4) chk("dbl_full_release", in_full, 0);
      step();
    end
    out_ready = 0;

    // Asynchronous reset in the middle of a stream.
    do_reset();
    for (int i = 0; i < IW; i++) begin wr_in = 1; in_data = W'(i + 1); step(); end
    wr_in = 0; in_data_ready = 1; step(); in_data_ready = 0;
    out_ready = 1;
    step();
    step();
    out_ready = 0;
    sys_rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_last", out_last, 0);
    chk("arst_in_full", in_full, 0);
    model_reset();
    step();
    sys_rst = 0;
    run_dir(tbl[0]);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      wr_in         = ($urandom_range(0, 2) != 0);
      in_data       = W'($urandom);
      in_data_ready = ($urandom_range(0, 9) == 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      sys_rst       = ($urandom_range(0, 599) == 0);
      step();
    end
    sys_rst = 0; wr_in = 0; in_data_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
